// File: rtl/ones_run_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ones_run_pkg
// Purpose  : Shared constants and report record for the ones-run reporter.
//            LEN_W_DEF is the default run-length width, LEN_MAX the saturated
//            count at that width, run_rpt_t the {sat, len} report layout.
// Revision : 1.0 - initial release
// ============================================================================
package ones_run_pkg;

    localparam int LEN_W_DEF = 8;

    localparam logic [LEN_W_DEF-1:0] LEN_MAX = '1;

    typedef struct packed {
        logic                 sat;
        logic [LEN_W_DEF-1:0] len;
    } run_rpt_t;

endpackage
`default_nettype wire

// File: rtl/run_rpt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : run_rpt_fifo
// Purpose  : Synchronous first-word-fall-through FIFO for run reports.
//            The head entry is visible on o_head whenever the FIFO is
//            non-empty; o_head reads zero while empty.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous reset, active-low
//            i_push    - write i_data (ignored when full unless popping)
//            i_data    - report to write
//            i_pop     - remove head entry (ignored when empty)
//            o_head    - head entry, zero when empty
//            o_full    - DEPTH entries stored
//            o_empty   - no entries stored
//            o_count   - number of stored entries
// Revision : 1.0 - initial release
// ============================================================================
module run_rpt_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_do_push;
    logic            w_do_pop;

    assign w_full    = (r_count == c_FULL);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    // A full FIFO still accepts a write when the head leaves on the same
    // edge: the freed slot is the one the write pointer already addresses.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only ever read while counted.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ones_run_reporter.sv
`default_nettype none
// ============================================================================
// Module   : ones_run_reporter
// Purpose  : Measures each run of 1s on x and queues one {sat, len} report
//            for every run during which the detector flag z was high.
//            Reports drain over a valid/ready interface.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous reset, active-low
//            x         - serial bit stream
//            z         - detector flag, only meaningful while x=1
//            m_valid   - report available
//            m_ready   - consumer accepts report
//            m_len     - run length of head report (zero when empty)
//            m_sat     - head report length saturated
//            drop_cnt  - dropped report count (DROP_COUNT_EN only)
// Config   : DROP_COUNT_EN - adds drop_cnt, a saturating count of reports
//            lost to a full FIFO; without it drops are silent.
// Revision : 1.0 - initial release
// ============================================================================
module ones_run_reporter
    import ones_run_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             z,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [LEN_W-1:0] m_len,
    output logic             m_sat
`ifdef DROP_COUNT_EN
    ,
    output logic [7:0]       drop_cnt
`endif
);

    localparam int               c_CW      = $clog2(DEPTH) + 1;
    localparam logic [LEN_W-1:0] c_LEN_MAX = '1;

    typedef struct packed {
        logic             sat;
        logic [LEN_W-1:0] len;
    } rpt_t;

    logic [LEN_W-1:0] r_run_len;
    logic             r_sat;
    logic             r_flag;

    logic             w_run_end;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [c_CW-1:0]  w_count;
    rpt_t             w_rpt_in;
    rpt_t             w_rpt_head;

    // Run tracking. The flag only accumulates z while x=1, so a z pulse on
    // the run-ending 0 cannot promote an unflagged run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_len <= '0;
            r_sat     <= 1'b0;
            r_flag    <= 1'b0;
        end else if (x) begin
            if (r_run_len != c_LEN_MAX) begin
                r_run_len <= r_run_len + 1'b1;
            end
            if (r_run_len >= c_LEN_MAX - 1'b1) begin
                r_sat <= 1'b1;
            end
            r_flag <= r_flag | z;
        end else begin
            r_run_len <= '0;
            r_sat     <= 1'b0;
            r_flag    <= 1'b0;
        end
    end

    assign w_run_end    = ~x & (r_run_len != '0);
    assign w_push       = w_run_end & r_flag;
    assign w_pop        = m_ready & ~w_empty;
    assign w_rpt_in.sat = r_sat;
    assign w_rpt_in.len = r_run_len;

    run_rpt_fifo #(
        .W     ($bits(rpt_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_rpt_in),
        .i_pop   (w_pop),
        .o_head  (w_rpt_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign m_valid = (w_count != '0);
    assign m_len   = w_rpt_head.len;
    assign m_sat   = w_rpt_head.sat;

`ifdef DROP_COUNT_EN
    logic       w_drop;
    logic [7:0] r_drop_cnt;

    // A push into a full FIFO only loses data when the head is not leaving
    // on the same edge.
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ones_run_reporter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ones_run_reporter
// Purpose  : Self-checking bench for ones_run_reporter: vector table,
//            directed multi-cycle sequences and randomized traffic against
//            a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ones_run_reporter;

    localparam int LW    = 8;
    localparam int DEPTH = 4;
    localparam int LMAX  = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          x = 1'b0;
    logic          z = 1'b0;
    logic          m_ready = 1'b0;
    logic          m_valid;
    logic          m_sat;
    logic [LW-1:0] m_len;
    logic          m4_valid;
    logic          m4_sat;
    logic [3:0]    m4_len;
`ifdef DROP_COUNT_EN
    logic [7:0]    drop_cnt;
    logic [7:0]    drop4_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ones_run_reporter #(.LEN_W(LW), .DEPTH(DEPTH)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .z        (z),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_len    (m_len),
        .m_sat    (m_sat)
`ifdef DROP_COUNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    ones_run_reporter #(.LEN_W(4), .DEPTH(DEPTH)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .z        (z),
        .m_valid  (m4_valid),
        .m_ready  (m_ready),
        .m_len    (m4_len),
        .m_sat    (m4_sat)
`ifdef DROP_COUNT_EN
        ,
        .drop_cnt (drop4_cnt)
`endif
    );

    // ---------------- reference model (LEN_W = 8 instance) ----------------
    typedef struct {
        int len;
        bit sat;
    } rpt_m_t;

    rpt_m_t mq[$];
    int     m_run   = 0;
    bit     m_flag  = 1'b0;
    int     m_drops = 0;
    int     consec  = 0;

    task automatic model_clear();
        mq.delete();
        m_run   = 0;
        m_flag  = 1'b0;
        m_drops = 0;
        consec  = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model over that clock edge,
    // then wait until just after the edge.
    task automatic step(input logic xi, input logic zi, input logic rdy);
        bit     pop;
        bit     full;
        rpt_m_t r;
        x       = xi;
        z       = zi;
        m_ready = rdy;
        pop  = rdy && (mq.size() > 0);
        full = (mq.size() == DEPTH);
        if (pop) r = mq.pop_front();
        if (!xi && m_run > 0 && m_flag) begin
            r.len = (m_run > LMAX) ? LMAX : m_run;
            r.sat = (m_run >= LMAX);
            if (!full || pop) mq.push_back(r);
            else if (m_drops < 255) m_drops++;
        end
        if (xi) begin
            m_run++;
            m_flag = m_flag | zi;
        end else begin
            m_run  = 0;
            m_flag = 1'b0;
        end
        consec = xi ? consec + 1 : 0;
        @(posedge clk);
        #1;
    endtask

    // n consecutive ones with the detector flag high from the 3rd one on
    task automatic run_ones(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, (i >= 2), rdy);
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        x       = 1'b0;
        z       = 1'b0;
        m_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, m_valid, (mq.size() > 0));
        chk({tag, "_len"},   m_len,   (mq.size() > 0) ? mq[0].len : 0);
        chk({tag, "_sat"},   m_sat,   (mq.size() > 0) ? mq[0].sat : 0);
`ifdef DROP_COUNT_EN
        chk({tag, "_drop"},  drop_cnt, m_drops);
`endif
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       x;
        logic       z;
        logic       rdy;
        logic       ev;
        logic [7:0] el;
        logic       es;
    } vec_t;

    function automatic vec_t mk(input logic xi, input logic zi, input logic r,
                                input logic ev, input logic [7:0] el, input logic es);
        vec_t v;
        v.x = xi; v.z = zi; v.rdy = r; v.ev = ev; v.el = el; v.es = es;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // run of 5, consumer always ready: one report for exactly one cycle
        tbl[0]  = mk(0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1, 0, 0, 0);
        tbl[2]  = mk(1, 0, 1, 0, 0, 0);
        tbl[3]  = mk(1, 1, 1, 0, 0, 0);
        tbl[4]  = mk(1, 1, 1, 0, 0, 0);
        tbl[5]  = mk(1, 1, 1, 0, 0, 0);
        tbl[6]  = mk(0, 0, 1, 1, 5, 0);
        tbl[7]  = mk(0, 0, 1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 0, 0, 0);
        // short unflagged runs, z with x=0 ignored
        tbl[9]  = mk(1, 0, 1, 0, 0, 0);
        tbl[10] = mk(1, 0, 1, 0, 0, 0);
        tbl[11] = mk(0, 0, 1, 0, 0, 0);
        tbl[12] = mk(0, 0, 1, 0, 0, 0);
        tbl[13] = mk(0, 1, 1, 0, 0, 0);
        tbl[14] = mk(1, 0, 1, 0, 0, 0);
        tbl[15] = mk(0, 1, 1, 0, 0, 0);

        // reset values, observed while reset is held
        rst = 1'b0;
        #2;
        chk("rst_valid", m_valid, 0);
        chk("rst_len",   m_len,   0);
        chk("rst_sat",   m_sat,   0);
`ifdef DROP_COUNT_EN
        chk("rst_drop",  drop_cnt, 0);
`endif
        do_reset();

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].x, tbl[i].z, tbl[i].rdy);
            chk($sformatf("vec%0d_valid", i), m_valid, tbl[i].ev);
            chk($sformatf("vec%0d_len", i),   m_len,   tbl[i].el);
            chk($sformatf("vec%0d_sat", i),   m_sat,   tbl[i].es);
        end

        // five flagged runs of 3 with consumer stalled: one dropped
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_ones(3, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        chk("full_valid", m_valid, 1);
`ifdef DROP_COUNT_EN
        chk("full_drop", drop_cnt, 1);
`endif
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_valid", k), m_valid, 1);
            chk($sformatf("drain%0d_len", k),   m_len,   3);
            step(1'b0, 1'b0, 1'b1);
        end
        chk("drained_valid", m_valid, 0);
        chk("drained_len",   m_len,   0);

        // full FIFO, push and pop on the same edge
        do_reset();
        for (int k = 3; k <= 6; k++) begin
            run_ones(k, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        run_ones(7, 1'b0);
        step(1'b0, 1'b0, 1'b1);
`ifdef DROP_COUNT_EN
        chk("pp_drop", drop_cnt, 0);
`endif
        for (int k = 4; k <= 7; k++) begin
            chk($sformatf("pp%0d_valid", k), m_valid, 1);
            chk($sformatf("pp%0d_len", k),   m_len,   k);
            step(1'b0, 1'b0, 1'b1);
        end
        chk("pp_empty", m_valid, 0);

        // saturation on the 4-bit instance
        do_reset();
        run_ones(20, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("sat4_valid", m4_valid, 1);
        chk("sat4_len",   m4_len,   15);
        chk("sat4_sat",   m4_sat,   1);
        chk("sat8_len",   m_len,    20);
        chk("sat8_sat",   m_sat,    0);
        step(1'b0, 1'b0, 1'b1);
        run_ones(14, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("len14_len", m4_len, 14);
        chk("len14_sat", m4_sat, 0);

        // asynchronous reset in the middle of a flagged run
        do_reset();
        run_ones(3, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("pre_rst_valid", m_valid, 1);
        run_ones(4, 1'b0);
        rst = 1'b0;
        #1;
        chk("async_valid", m_valid, 0);
        chk("async_len",   m_len,   0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1);
            chk($sformatf("post_rst%0d_valid", k), m_valid, 0);
            chk($sformatf("post_rst%0d_len", k),   m_len,   0);
            chk($sformatf("post_rst%0d_sat", k),   m_sat,   0);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("post_rst_short", m_valid, 0);

        // randomized traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            logic xi;
            logic zi;
            logic ri;
            xi = ($urandom_range(0, 9) < 6);
            zi = xi ? ((consec + 1) >= 3) : 1'($urandom_range(0, 1));
            ri = ($urandom_range(0, 99) < ((cyc % 200) < 100 ? 20 : 75));
            step(xi, zi, ri);
            check_model($sformatf("rnd%0d", cyc));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
